// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared FSM state type, default timing constants and width helper
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESSED      = 2'd1,
        RST_PULSE    = 2'd2,
        WAIT_RELEASE = 2'd3
    } btn_fsm_e;

    localparam int DEF_DEBOUNCE_CYCLES   = 480000;
    localparam int DEF_LONG_PRESS_CYCLES = 96000000;
    localparam int DEF_RST_PULSE_CYCLES  = 4800;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer and stable-level debouncer
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_N,
    output logic BTN_STATE
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          btn_sync;
    logic [DW-1:0] db_cnt;
    logic          state_q;

    // Flops hold the pressed polarity so reset leaves them at "released";
    // btn_sync is registered once more, giving the DEBOUNCE_CYCLES+2 latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            btn_sync <= 1'b0;
            db_cnt   <= '0;
            state_q  <= 1'b0;
        end else begin
            sync_q1  <= ~BTN_N;
            sync_q2  <= sync_q1;
            btn_sync <= sync_q2;
            if (btn_sync == state_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                state_q <= ~state_q;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign BTN_STATE = state_q;

endmodule

// File: rtl/btn_reset_ctrl.sv
// rtl/btn_reset_ctrl.sv - press classifier with long-press board reset pulse
module btn_reset_ctrl
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int RST_PULSE_CYCLES  = DEF_RST_PULSE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_N,
    input  logic RST_EN,
    output logic BTN_STATE,
    output logic PRESS,
    output logic SHORT_PRESS,
    output logic LONG_PRESS,
    output logic RST_N
);

    localparam int HW = cnt_width(LONG_PRESS_CYCLES);
    localparam int PW = cnt_width(RST_PULSE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);

    btn_fsm_e      state_q;
    btn_fsm_e      state_d;
    logic [HW-1:0] hold_q;
    logic [PW-1:0] pulse_q;
    logic          rst_n_q;
    logic          btn_level;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK       (CLK),
        .RST       (RST),
        .BTN_N     (BTN_N),
        .BTN_STATE (btn_level)
    );

    assign BTN_STATE = btn_level;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rst_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            rst_n_q <= (state_d != RST_PULSE);
        end
    end

    // hold_q counts cycles since the PRESS cycle, so it reads 0 on PRESS.
    always_ff @(posedge CLK) begin
        if (RST || (state_q == IDLE && !btn_level)) begin
            hold_q <= '0;
        end else if (hold_q != {HW{1'b1}}) begin
            hold_q <= hold_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || state_q != RST_PULSE) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (btn_level) state_d = PRESSED;
            end
            PRESSED: begin
                if (!btn_level) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RST_EN ? RST_PULSE : WAIT_RELEASE;
                end
            end
            RST_PULSE: begin
                if (pulse_q == PULSE_LAST) state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!btn_level) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Release is checked before the threshold so a coincident release wins.
    always_comb begin
        PRESS       = 1'b0;
        SHORT_PRESS = 1'b0;
        LONG_PRESS  = 1'b0;
        if (!RST) begin
            PRESS       = (state_q == IDLE) && btn_level;
            SHORT_PRESS = (state_q == PRESSED) && !btn_level;
            LONG_PRESS  = (state_q == PRESSED) && btn_level && (hold_q == HOLD_LAST);
        end
    end

    assign RST_N = rst_n_q;

endmodule

// File: tb/tb_btn_reset_ctrl.sv
// tb/tb_btn_reset_ctrl.sv - directed-vector bench for btn_reset_ctrl
module tb_btn_reset_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic BTN_N;
    logic RST_EN;
    logic BTN_STATE;
    logic PRESS;
    logic SHORT_PRESS;
    logic LONG_PRESS;
    logic RST_N;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int press_cnt, press_at, short_cnt, short_at, long_cnt, long_at;
    int lo_cnt, lo_first, lo_last;
    int e;
    int r;

    always #5 CLK = ~CLK;

    btn_reset_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20),
        .RST_PULSE_CYCLES  (3)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTN_N       (BTN_N),
        .RST_EN      (RST_EN),
        .BTN_STATE   (BTN_STATE),
        .PRESS       (PRESS),
        .SHORT_PRESS (SHORT_PRESS),
        .LONG_PRESS  (LONG_PRESS),
        .RST_N       (RST_N)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        press_cnt = 0; press_at = -1;
        short_cnt = 0; short_at = -1;
        long_cnt  = 0; long_at  = -1;
        lo_cnt    = 0; lo_first = -1; lo_last = -1;
    endtask

    // one edge, then sample 1 time unit later and log pulses against edge index
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            cyc++;
            #1;
            if (PRESS)       begin press_cnt++; press_at = cyc; end
            if (SHORT_PRESS) begin short_cnt++; short_at = cyc; end
            if (LONG_PRESS)  begin long_cnt++;  long_at  = cyc; end
            if (!RST_N) begin
                if (lo_cnt == 0) lo_first = cyc;
                lo_cnt++;
                lo_last = cyc;
            end
        end
    endtask

    initial begin
        RST    = 1'b1;
        BTN_N  = 1'b1;
        RST_EN = 1'b0;
        clear_stats();
        tick(3);
        check_val("rst_btn_state", BTN_STATE, 0);
        check_val("rst_press", PRESS, 0);
        check_val("rst_short", SHORT_PRESS, 0);
        check_val("rst_long", LONG_PRESS, 0);
        check_val("rst_rst_n", RST_N, 1);
        RST = 1'b0;
        tick(2);

        // bounce: 3 low, 2 high, then held low from edge E
        clear_stats();
        BTN_N = 1'b0; tick(3);
        BTN_N = 1'b1; tick(2);
        BTN_N = 1'b0; e = cyc + 1;
        tick(6);
        check_val("bounce_no_press", press_cnt, 0);
        check_val("bounce_state_low", BTN_STATE, 0);
        tick(1);
        check_val("bounce_state_e6", BTN_STATE, 1);
        check_val("bounce_press_e6", PRESS, 1);

        // short press: hold 10 cycles after PRESS, then release
        tick(10);
        BTN_N = 1'b1; r = cyc + 1;
        tick(12);
        check_val("short_cnt", short_cnt, 1);
        check_val("short_at", short_at - r, 6);
        check_val("short_no_long", long_cnt, 0);
        check_val("short_no_rst", lo_cnt, 0);
        check_val("short_press_once", press_cnt, 1);

        // long press with reset enabled
        clear_stats();
        RST_EN = 1'b1;
        BTN_N = 1'b0; e = cyc + 1;
        tick(40);
        BTN_N = 1'b1;
        tick(12);
        check_val("longen_press_at", press_at - e, 6);
        check_val("longen_long_cnt", long_cnt, 1);
        check_val("longen_long_at", long_at - press_at, 19);
        check_val("longen_lo_first", lo_first - press_at, 20);
        check_val("longen_lo_cnt", lo_cnt, 3);
        check_val("longen_lo_last", lo_last - press_at, 22);
        check_val("longen_no_short", short_cnt, 0);
        check_val("longen_rst_n_end", RST_N, 1);

        // long press with reset disabled
        clear_stats();
        RST_EN = 1'b0;
        BTN_N = 1'b0; e = cyc + 1;
        tick(40);
        BTN_N = 1'b1;
        tick(12);
        check_val("longdis_long_cnt", long_cnt, 1);
        check_val("longdis_long_at", long_at - e, 25);
        check_val("longdis_no_rst", lo_cnt, 0);
        check_val("longdis_no_short", short_cnt, 0);
        check_val("longdis_state", BTN_STATE, 0);

        // release lands on the threshold cycle: BTN_STATE falls when hold reads 19
        clear_stats();
        RST_EN = 1'b1;
        BTN_N = 1'b0; e = cyc + 1;
        tick(19);
        BTN_N = 1'b1;
        tick(12);
        check_val("thr_press_at", press_at - e, 6);
        check_val("thr_short_cnt", short_cnt, 1);
        check_val("thr_short_at", short_at - press_at, 19);
        check_val("thr_no_long", long_cnt, 0);
        check_val("thr_no_rst", lo_cnt, 0);

        // reset during the second RST_N-low cycle, button kept held
        clear_stats();
        RST_EN = 1'b1;
        BTN_N = 1'b0; e = cyc + 1;
        for (int k = 0; k < 60 && RST_N; k++) tick(1);
        check_val("mid_pulse_seen", RST_N, 0);
        check_val("mid_pulse_first", lo_first - press_at, 20);
        tick(1);
        check_val("mid_pulse_second", RST_N, 0);
        RST = 1'b1;
        tick(1);
        check_val("mid_rst_rst_n", RST_N, 1);
        check_val("mid_rst_state", BTN_STATE, 0);
        check_val("mid_rst_press", PRESS, 0);
        check_val("mid_rst_short", SHORT_PRESS, 0);
        check_val("mid_rst_long", LONG_PRESS, 0);
        RST = 1'b0;
        clear_stats();
        e = cyc + 1;
        tick(12);
        check_val("post_rst_press_cnt", press_cnt, 1);
        check_val("post_rst_press_at", press_at - e, 6);
        check_val("post_rst_no_rst", lo_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_reset_ctrl.md
BTN_RESET_CTRL -- requirements
Module: btn_reset_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 480000 (10 ms at 48 MHz): cycles the synchronized button must be stable before the debounced level changes.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 96000000 (2 s): press duration that classifies a press as long.
REQ-003 SHALL have parameter RST_PULSE_CYCLES, default 4800 (100 us): low width of the RST_N pulse.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port BTN_N, input, 1 bit: raw asynchronous button, low = pressed.
REQ-007 SHALL have port RST_EN, input, 1 bit: when 1, a long press drives an RST_N pulse.
REQ-008 SHALL have port BTN_STATE, output, 1 bit: debounced level, 1 = pressed.
REQ-009 SHALL have port PRESS, output, 1 bit: one-cycle pulse on the debounced press.
REQ-010 SHALL have port SHORT_PRESS, output, 1 bit: one-cycle pulse on a release before the long threshold.
REQ-011 SHALL have port LONG_PRESS, output, 1 bit: one-cycle pulse when the long threshold is reached.
REQ-012 SHALL have port RST_N, output, 1 bit: active-low reset or reconfiguration request to the board.

Function
REQ-013 BTN_N SHALL pass through a 2-flop synchronizer and be inverted, giving btn_sync (1 = pressed).
REQ-014 Debounce rules:
- The counter clears whenever btn_sync equals BTN_STATE.
- Otherwise it increments.
- BTN_STATE toggles and the counter clears on the cycle the counter reaches DEBOUNCE_CYCLES-1 while btn_sync still differs.
REQ-015 Latency: BTN_STATE SHALL change exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples a new stable BTN_N level.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change BTN_STATE.
REQ-017 The FSM SHALL have the states IDLE, PRESSED, RST_PULSE and WAIT_RELEASE.
REQ-018 IDLE behaviour:
- On a BTN_STATE 0->1 transition, the FSM goes to PRESSED.
- PRESS is 1 in the same cycle that BTN_STATE first reads 1.
- The hold counter loads 0.
REQ-019 PRESSED behaviour:
- The hold counter increments each cycle.
- On BTN_STATE 0, the FSM goes to IDLE with a SHORT_PRESS pulse.
- On hold counter == LONG_PRESS_CYCLES-1, the FSM pulses LONG_PRESS and goes to RST_PULSE if RST_EN=1, else to WAIT_RELEASE.
REQ-020 If release and threshold coincide in the same cycle, release SHALL win: SHORT_PRESS pulses and LONG_PRESS does not.
REQ-021 RST_PULSE behaviour:
- RST_N is 0 for exactly RST_PULSE_CYCLES cycles, starting the cycle after LONG_PRESS.
- The FSM then goes to WAIT_RELEASE.
- Button release during the pulse does not shorten the pulse.
REQ-022 WAIT_RELEASE SHALL go to IDLE on BTN_STATE 0, with no pulse.
REQ-023 RST_EN SHALL be sampled only on the threshold cycle; a change of RST_EN during RST_PULSE has no effect.
REQ-024 The hold counter SHALL saturate and never wrap.
REQ-025 Counter widths SHALL be $clog2 of their parameter, with a minimum of 1.
REQ-026 RST_N SHALL be a registered output and is 1 in every state except RST_PULSE.
REQ-027 PRESS, SHORT_PRESS and LONG_PRESS SHALL each be high for at most one cycle per press.

Reset
REQ-028 While RST=1, all of the following SHALL hold:
- Synchronizer flops hold 0 (released).
- BTN_STATE=0.
- The FSM is in IDLE.
- All counters are 0.
- PRESS, SHORT_PRESS and LONG_PRESS are 0.
- RST_N=1.
REQ-029 RST asserted mid-pulse SHALL return RST_N to 1 on the next edge.
REQ-030 After RST is released with the button held, the block SHALL report a fresh PRESS after the debounce latency.

Structure
REQ-031 Package btn_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-032 Synchronizer and debounce logic SHALL be sub-module btn_debounce (ports CLK, RST, BTN_N, BTN_STATE), instanced once.

Verification
Parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, RST_PULSE_CYCLES=3. Edge E is the first edge sampling the new BTN_N level.
REQ-033 Bounce test: BTN_N low for 3 cycles, high for 2, then low and held from edge E.
- Required: no PRESS during the bounce.
- Required: BTN_STATE=1 and PRESS=1 at edge E+6.
REQ-034 Short press: hold 10 cycles after PRESS, then release.
- Required: SHORT_PRESS pulses once, at release edge +6.
- Required: no LONG_PRESS and RST_N stays 1.
REQ-035 Long press with RST_EN=1: hold for 40 cycles.
- Required: LONG_PRESS at PRESS+19.
- Required: RST_N=0 for exactly 3 cycles starting at PRESS+20.
- Required: no SHORT_PRESS on release.
REQ-036 Long press with RST_EN=0: hold for 40 cycles.
- Required: LONG_PRESS pulses and RST_N stays 1.
- Required: the FSM returns to IDLE 6 cycles after release.
REQ-037 Release on the threshold: release timed so BTN_STATE falls on the cycle the hold counter reads 19.
- Required: SHORT_PRESS=1, LONG_PRESS=0, RST_N=1.
REQ-038 Reset mid-pulse: assert RST during the second RST_N-low cycle.
- Required: RST_N=1 on the next edge and all outputs at reset values.
- Required: with the button still held after RST is released, PRESS fires 6 cycles later.
